// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: enable, synchronous clamped load, wrap or saturate at limits,
// registered limit flags and wrap pulse; optional terminal-count pulse under UPDOWN_CNT_TC_EN.
module updown_counter_param #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter int MIN_VAL = 0,
  parameter int STEP    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap_pulse
`ifdef UPDOWN_CNT_TC_EN
  ,
  input  logic [WIDTH-1:0] tc_val,
  output logic             tc
`endif
);

  // All limit arithmetic is one bit wider than the count so sums never truncate.
  localparam logic [WIDTH:0] MAXV  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] MINV  = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0] STEPV = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] ONE   = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] DN_FLOOR = MINV + STEPV;

  logic [WIDTH:0] cur;
  logic [WIDTH:0] ld;
  logic [WIDTH:0] up_sum;
  logic [WIDTH:0] nxt;
  logic           wrap_nxt;
  logic           cnt_evt;

  always_comb begin
    cur      = {1'b0, count};
    ld       = {1'b0, load_val};
    up_sum   = cur + STEPV;
    nxt      = cur;
    wrap_nxt = 1'b0;
    cnt_evt  = 1'b0;
    if (load) begin
      if (ld > MAXV)      nxt = MAXV;
      else if (ld < MINV) nxt = MINV;
      else                nxt = ld;
    end else if (en) begin
      // An out-of-range count (only reachable after X-recovery) is pulled back first.
      if (cur > MAXV) begin
        nxt = MAXV;
      end else if (cur < MINV) begin
        nxt = MINV;
      end else if (dir) begin
        cnt_evt = 1'b1;
        if (up_sum <= MAXV) begin
          nxt = up_sum;
        end else if (sat_mode) begin
          nxt = MAXV;
        end else begin
          nxt      = MINV + (up_sum - MAXV - ONE);
          wrap_nxt = 1'b1;
        end
      end else begin
        cnt_evt = 1'b1;
        // count-STEP >= MIN_VAL rewritten as count >= MIN_VAL+STEP to stay unsigned.
        if (cur >= DN_FLOOR) begin
          nxt = cur - STEPV;
        end else if (sat_mode) begin
          nxt = MINV;
        end else begin
          nxt      = MAXV - (DN_FLOOR - cur - ONE);
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= MINV[WIDTH-1:0];
      at_max     <= 1'b0;
      at_min     <= 1'b1;
      wrap_pulse <= 1'b0;
    end else begin
      count      <= nxt[WIDTH-1:0];
      at_max     <= (nxt == MAXV);
      at_min     <= (nxt == MINV);
      wrap_pulse <= wrap_nxt;
    end
  end

`ifdef UPDOWN_CNT_TC_EN
  // Pulse only when counting moves the value onto tc_val; a held saturated value does not re-fire.
  always_ff @(posedge clk) begin
    if (rst) begin
      tc <= 1'b0;
    end else begin
      tc <= cnt_evt && (nxt[WIDTH-1:0] == tc_val) && (nxt != cur);
    end
  end
`endif

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three configurations share one stimulus stream and are
// checked every cycle against an integer model, plus hand-computed literal expectations.
module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       rst, en, dir, sat, load;
  logic [4:0] lv;
  logic [4:0] tv;

  logic [3:0] ca, cb;
  logic [4:0] cc;
  logic       amax_a, amin_a, wp_a, amax_b, amin_b, wp_b, amax_c, amin_c, wp_c;
  logic       tc_a, tc_b, tc_c;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(4)) ua (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .sat_mode(sat), .load(load),
    .load_val(lv[3:0]), .count(ca), .at_max(amax_a), .at_min(amin_a), .wrap_pulse(wp_a)
`ifdef UPDOWN_CNT_TC_EN
    , .tc_val(tv[3:0]), .tc(tc_a)
`endif
  );

  updown_counter_param #(.WIDTH(4), .MAX_VAL(12), .MIN_VAL(3), .STEP(4)) ub (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .sat_mode(sat), .load(load),
    .load_val(lv[3:0]), .count(cb), .at_max(amax_b), .at_min(amin_b), .wrap_pulse(wp_b)
`ifdef UPDOWN_CNT_TC_EN
    , .tc_val(tv[3:0]), .tc(tc_b)
`endif
  );

  updown_counter_param #(.WIDTH(5), .MAX_VAL(18)) uc (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .sat_mode(sat), .load(load),
    .load_val(lv), .count(cc), .at_max(amax_c), .at_min(amin_c), .wrap_pulse(wp_c)
`ifdef UPDOWN_CNT_TC_EN
    , .tc_val(tv), .tc(tc_c)
`endif
  );

`ifndef UPDOWN_CNT_TC_EN
  assign tc_a = 1'b0;
  assign tc_b = 1'b0;
  assign tc_c = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int MN [3] = '{0, 3, 0};
  localparam int MX [3] = '{15, 12, 18};
  localparam int ST [3] = '{1, 4, 1};
  int m_cnt [3];
  bit m_wrap [3];
  bit m_tc [3];
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int lvk, tvk, n;
      lvk = (k == 2) ? int'(lv) : int'(lv[3:0]);
      tvk = (k == 2) ? int'(tv) : int'(tv[3:0]);
      m_wrap[k] = 1'b0;
      m_tc[k]   = 1'b0;
      if (rst) begin
        m_cnt[k] = MN[k];
      end else if (load) begin
        m_cnt[k] = (lvk > MX[k]) ? MX[k] : (lvk < MN[k]) ? MN[k] : lvk;
      end else if (en) begin
        if (dir) begin
          n = m_cnt[k] + ST[k];
          if (n > MX[k]) begin
            if (sat) n = MX[k];
            else begin n = MN[k] + (n - MX[k] - 1); m_wrap[k] = 1'b1; end
          end
        end else begin
          n = m_cnt[k] - ST[k];
          if (n < MN[k]) begin
            if (sat) n = MN[k];
            else begin n = MX[k] - (MN[k] - n - 1); m_wrap[k] = 1'b1; end
          end
        end
`ifdef UPDOWN_CNT_TC_EN
        m_tc[k] = (n == tvk) && (n != m_cnt[k]);
`endif
        m_cnt[k] = n;
      end
    end
    if (rst) m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_cnt_a", 32'(ca), 32'(m_cnt[0]));
      chk("m_max_a", 32'(amax_a), 32'(m_cnt[0] == MX[0]));
      chk("m_min_a", 32'(amin_a), 32'(m_cnt[0] == MN[0]));
      chk("m_wrap_a", 32'(wp_a), 32'(m_wrap[0]));
      chk("m_cnt_b", 32'(cb), 32'(m_cnt[1]));
      chk("m_max_b", 32'(amax_b), 32'(m_cnt[1] == MX[1]));
      chk("m_min_b", 32'(amin_b), 32'(m_cnt[1] == MN[1]));
      chk("m_wrap_b", 32'(wp_b), 32'(m_wrap[1]));
      chk("m_cnt_c", 32'(cc), 32'(m_cnt[2]));
      chk("m_max_c", 32'(amax_c), 32'(m_cnt[2] == MX[2]));
      chk("m_min_c", 32'(amin_c), 32'(m_cnt[2] == MN[2]));
      chk("m_wrap_c", 32'(wp_c), 32'(m_wrap[2]));
`ifdef UPDOWN_CNT_TC_EN
      chk("m_tc_a", 32'(tc_a), 32'(m_tc[0]));
      chk("m_tc_b", 32'(tc_b), 32'(m_tc[1]));
      chk("m_tc_c", 32'(tc_c), 32'(m_tc[2]));
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1; en = 0; dir = 0; sat = 0; load = 0; lv = 0; tv = 5'd7;
    tick(); tick();
    chk("rst_cnt_a", 32'(ca), 0);
    chk("rst_min_a", 32'(amin_a), 1);
    chk("rst_max_a", 32'(amax_a), 0);
    chk("rst_wrap_a", 32'(wp_a), 0);
    chk("rst_cnt_b", 32'(cb), 3);

    // Count up through full range and wrap.
    rst = 0; en = 1; dir = 1; sat = 0;
    repeat (15) tick();
    chk("up15_cnt", 32'(ca), 15);
    chk("up15_max", 32'(amax_a), 1);
    chk("up15_wrap", 32'(wp_a), 0);
    tick();
    chk("wrap0_cnt", 32'(ca), 0);
    chk("wrap0_pulse", 32'(wp_a), 1);
    tick();
    chk("post_wrap_cnt", 32'(ca), 1);
    chk("post_wrap_pulse", 32'(wp_a), 0);

    // Down from 0: wrap then saturate.
    rst = 1; tick();
    rst = 0; dir = 0; tick();
    chk("dn_wrap_cnt", 32'(ca), 15);
    chk("dn_wrap_pulse", 32'(wp_a), 1);
    rst = 1; tick();
    rst = 0; sat = 1; tick();
    chk("dn_sat_cnt", 32'(ca), 0);
    chk("dn_sat_min", 32'(amin_a), 1);
    chk("dn_sat_pulse", 32'(wp_a), 0);

    // Non-zero MIN, STEP=4 wrap both ways.
    sat = 0; load = 1; lv = 5'd11; tick();
    chk("b_load11", 32'(cb), 11);
    load = 0; dir = 1; tick();
    chk("b_upwrap_cnt", 32'(cb), 5);
    chk("b_upwrap_pulse", 32'(wp_b), 1);
    dir = 0; tick();
    chk("b_dnwrap_cnt", 32'(cb), 11);
    chk("b_dnwrap_pulse", 32'(wp_b), 1);

    // Load clamping above max and below min.
    load = 1; lv = 5'd20; tick();
    chk("c_clamp_cnt", 32'(cc), 18);
    chk("c_clamp_max", 32'(amax_c), 1);
    chk("c_clamp_wrap", 32'(wp_c), 0);
    lv = 5'd1; tick();
    chk("b_clamp_lo", 32'(cb), 3);
    chk("b_clamp_min", 32'(amin_b), 1);

    // Hold with en=0, then reset overrides load.
    lv = 5'd9; tick();
    chk("a_load9", 32'(ca), 9);
    load = 0; en = 0; tick(); tick();
    chk("a_hold9", 32'(ca), 9);
    chk("a_hold_wrap", 32'(wp_a), 0);
    rst = 1; load = 1; en = 1; tick();
    chk("rst_over_load_a", 32'(ca), 0);
    chk("rst_over_load_b", 32'(cb), 3);
    rst = 0; load = 0; en = 0; tick();
    chk("hold_after_rst", 32'(ca), 0);

    // Saturate up.
    load = 1; en = 1; lv = 5'd14; tick();
    load = 0; dir = 1; sat = 1;
    repeat (3) tick();
    chk("a_sat_up_cnt", 32'(ca), 15);
    chk("a_sat_up_wrap", 32'(wp_a), 0);
    chk("c_sat_up_cnt", 32'(cc), 17);

    // Mixed command table, checked by the model.
    for (int i = 0; i < 24; i++) begin
      en   = (i % 5) != 0;
      dir  = ((i / 2) % 2) != 0;
      sat  = ((i / 4) % 2) != 0;
      load = (i % 7) == 3;
      lv   = 5'(i * 3);
      tick();
    end

`ifdef UPDOWN_CNT_TC_EN
    load = 0; rst = 1; tv = 5'd7; tick();
    rst = 0; en = 1; dir = 1; sat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("tc_up", 32'(tc_a), 32'(i == 7));
    end
    load = 1; lv = 5'd7; tick();
    chk("tc_load7_cnt", 32'(ca), 7);
    chk("tc_load7", 32'(tc_a), 0);
    load = 0;
`endif

    en = 0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
